// File: rtl/store_buffer_if.sv
// Memory-side bus of the store buffer: asynchronous read port plus valid/ready write port.
// The master is the buffer and the slave is data memory.
interface store_buffer_if #(
  parameter int WORD = 32
);
  logic [WORD-1:0] mem_raddr;
  logic [WORD-1:0] mem_rdata;
  logic            mem_wvalid;
  logic            mem_wready;
  logic [WORD-1:0] mem_waddr;
  logic [WORD-1:0] mem_wdata;

  modport master (
    output mem_raddr,
    input  mem_rdata,
    output mem_wvalid,
    input  mem_wready,
    output mem_waddr,
    output mem_wdata
  );

  modport slave (
    input  mem_raddr,
    output mem_rdata,
    input  mem_wvalid,
    output mem_wready,
    input  mem_waddr,
    input  mem_wdata
  );
endinterface

// File: rtl/store_buffer.sv
// Word-granular FIFO write buffer between the core data port and data memory.
// Loads forward from the youngest queued store to the same word, else read memory.
module store_buffer #(
  parameter  int DEPTH = 4,
  parameter  int WORD  = 32,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            memwrite,
  input  logic [WORD-1:0] addr,
  input  logic [WORD-1:0] wdata,
  output logic [WORD-1:0] rdata,
  output logic            stall,
  output logic            empty,
  output logic [CW-1:0]   count,
  store_buffer_if.master  mem
);
  localparam int PW = $clog2(DEPTH);
  localparam int AW = WORD - 2;

  logic [AW-1:0]   addr_mem_r [DEPTH];
  logic [WORD-1:0] data_mem_r [DEPTH];
  logic [PW-1:0]   head_r;
  logic [PW-1:0]   tail_r;
  logic [CW-1:0]   count_r;

  logic            full_s;
  logic            enq_s;
  logic            deq_s;
  logic            wvalid_s;
  logic [PW-1:0]   idx_s;
  logic [WORD-1:0] fwd_s;

  // Handshake qualifiers; enqueue is blocked while full or in reset.
  always_comb begin
    full_s   = (count_r == CW'(DEPTH));
    wvalid_s = (count_r != '0);
    enq_s    = memwrite & ~full_s & ~reset;
    deq_s    = wvalid_s & mem.mem_wready;
  end

  // Walk entries oldest to youngest so the youngest matching store wins.
  always_comb begin
    fwd_s = mem.mem_rdata;
    idx_s = head_r;
    for (int k = 0; k < DEPTH; k++) begin
      idx_s = head_r + PW'(k);
      fwd_s = ((CW'(k) < count_r) && (addr_mem_r[idx_s] == addr[WORD-1:2]))
              ? data_mem_r[idx_s] : fwd_s;
    end
  end

  // Core-facing and memory-facing outputs.
  always_comb begin
    rdata          = fwd_s;
    stall          = memwrite & full_s;
    empty          = ~wvalid_s;
    count          = count_r;
    mem.mem_raddr  = addr;
    mem.mem_wvalid = wvalid_s;
    mem.mem_waddr  = {addr_mem_r[head_r], 2'b00};
    mem.mem_wdata  = data_mem_r[head_r];
  end

  // Entry storage needs no reset: only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      addr_mem_r[tail_r] <= addr[WORD-1:2];
      data_mem_r[tail_r] <= wdata;
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (enq_s) begin
        tail_r <= tail_r + PW'(1'b1);
      end
      if (deq_s) begin
        head_r <= head_r + PW'(1'b1);
      end
      count_r <= count_r + CW'(enq_s) - CW'(deq_s);
    end
  end
endmodule
